// File: rtl/afifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray-code conversion and the
// legal synchroniser depth range.
package afifo_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Out-of-range depths are pulled back into the legal window.
    function automatic int sync_stages_legal(input int n);
        if (n < SYNC_STAGES_MIN) begin
            return SYNC_STAGES_MIN;
        end else if (n > SYNC_STAGES_MAX) begin
            return SYNC_STAGES_MAX;
        end else begin
            return n;
        end
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
        logic [31:0] bin_m;
        bin_m = bin & ((32'd1 << width) - 32'd1);
        return bin_m ^ (bin_m >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
        logic [31:0] bin;
        bin = gray & ((32'd1 << width) - 32'd1);
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ bin[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/afifo_ptr_sync.sv
// N-stage synchroniser carrying a Gray-coded pointer into another clock domain.
module afifo_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift register; only one bit of a Gray pointer changes per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i - 1];
            end
        end
    end

    assign q = stage_r[STAGES - 1];

endmodule

// File: rtl/async_fifo_fwft.sv
// Dual-clock FIFO with Gray pointer crossing, registered status flags, sticky
// error flags and a selectable first-word-fall-through read port.
module async_fifo_fwft
    import afifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 1
) (
    input  logic              wr_clk,
    input  logic              wr_rst_n,
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_overflow,
    input  logic              wr_err_clr,
    input  logic [ADDR_W:0]   cfg_af_thresh,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_underflow,
    input  logic              rd_err_clr,
    input  logic [ADDR_W:0]   cfg_ae_thresh
);

    localparam int PW     = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int SYNC_N = sync_stages_legal(SYNC_STAGES);

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [PW-1:0] wr_ptr_r, wr_gray_r, rq_gray_s, rq_bin_s;
    logic [PW-1:0] wr_ptr_nxt_s, wr_level_nxt_s;
    logic          wr_accept_s;

    logic [PW-1:0] rd_ptr_r, rd_gray_r, wq_gray_s, wq_bin_s;
    logic [PW-1:0] rd_ptr_nxt_s, ram_cnt_nxt_s, rd_level_nxt_s;
    logic          ram_empty_r, rd_pop_s, out_valid_nxt_s, rd_underflow_set_s;

    afifo_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_N)) u_wr2rd (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .d     (wr_gray_r),
        .q     (wq_gray_s)
    );

    afifo_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_N)) u_rd2wr (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .d     (rd_gray_r),
        .q     (rq_gray_s)
    );

    // Write-side next-state: status is judged against the post-write pointer.
    always_comb begin
        wr_accept_s    = wr_en && !full;
        wr_ptr_nxt_s   = wr_ptr_r + {{ADDR_W{1'b0}}, wr_accept_s};
        rq_bin_s       = PW'(gray2bin(32'(rq_gray_s), PW));
        wr_level_nxt_s = wr_ptr_nxt_s - rq_bin_s;
    end

    // Write-domain pointer, Gray image and registered flags.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_ptr_r    <= '0;
            wr_gray_r   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            wr_overflow <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            wr_gray_r   <= PW'(bin2gray(32'(wr_ptr_r), PW));
            full        <= (wr_level_nxt_s == PW'(DEPTH));
            almost_full <= (wr_level_nxt_s >= cfg_af_thresh);
            wr_level    <= wr_level_nxt_s;
            if (wr_err_clr) begin
                wr_overflow <= 1'b0;
            end else if (wr_en && full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    // Storage array, intentionally without reset so it maps onto RAM.
    always_ff @(posedge wr_clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Read-side next-state; FWFT keeps its output register topped up.
    always_comb begin
        wq_bin_s = PW'(gray2bin(32'(wq_gray_s), PW));
        if (FWFT != 0) begin
            rd_pop_s           = !ram_empty_r && (!rd_valid || rd_en);
            out_valid_nxt_s    = rd_pop_s || (rd_valid && !rd_en);
            rd_underflow_set_s = rd_en && !rd_valid;
        end else begin
            rd_pop_s           = rd_en && !ram_empty_r;
            out_valid_nxt_s    = rd_pop_s;
            rd_underflow_set_s = rd_en && ram_empty_r;
        end
        rd_ptr_nxt_s  = rd_ptr_r + {{ADDR_W{1'b0}}, rd_pop_s};
        ram_cnt_nxt_s = wq_bin_s - rd_ptr_nxt_s;
        if (FWFT != 0) begin
            rd_level_nxt_s = ram_cnt_nxt_s + {{ADDR_W{1'b0}}, out_valid_nxt_s};
        end else begin
            rd_level_nxt_s = ram_cnt_nxt_s;
        end
    end

    // Read-domain pointer, Gray image, output word and registered flags.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ptr_r     <= '0;
            rd_gray_r    <= '0;
            ram_empty_r  <= 1'b1;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rd_underflow <= 1'b0;
        end else begin
            rd_ptr_r     <= rd_ptr_nxt_s;
            rd_gray_r    <= PW'(bin2gray(32'(rd_ptr_r), PW));
            ram_empty_r  <= (ram_cnt_nxt_s == '0);
            rd_valid     <= out_valid_nxt_s;
            if (rd_pop_s) begin
                rd_data <= mem_r[rd_ptr_r[ADDR_W-1:0]];
            end
            empty        <= (FWFT != 0) ? !out_valid_nxt_s : (ram_cnt_nxt_s == '0);
            almost_empty <= (rd_level_nxt_s <= cfg_ae_thresh);
            rd_level     <= rd_level_nxt_s;
            if (rd_err_clr) begin
                rd_underflow <= 1'b0;
            end else if (rd_underflow_set_s) begin
                rd_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_fwft.sv
// Scoreboard bench: instance 0 runs standard read mode, instance 1 runs FWFT.
`timescale 1ns/1ps
module tb_async_fifo_fwft;

    localparam int SS    = 2;
    localparam int NWORD = 2000;

    logic    wr_clk = 1'b0;
    logic    rd_clk = 1'b0;
    realtime wr_half = 5.0;
    realtime rd_half = 7.0;

    always #(wr_half) wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    logic       wr_rst_n, rd_rst_n, wr_err_clr, rd_err_clr;
    logic [3:0] cfg_af_thresh, cfg_ae_thresh;
    logic       wr_en [2];
    logic [7:0] wr_data [2];
    logic       rd_en [2];
    logic       full [2], almost_full [2], wr_overflow [2];
    logic       rd_valid [2], empty [2], almost_empty [2], rd_underflow [2];
    logic [3:0] wr_level [2], rd_level [2];
    logic [7:0] rd_data [2];

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sb_q0 [$];
    logic [7:0] sb_q1 [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        async_fifo_fwft #(.DATA_W(8), .ADDR_W(3), .SYNC_STAGES(SS), .FWFT(g)) u_dut (
            .wr_clk        (wr_clk),
            .wr_rst_n      (wr_rst_n),
            .rd_clk        (rd_clk),
            .rd_rst_n      (rd_rst_n),
            .wr_en         (wr_en[g]),
            .wr_data       (wr_data[g]),
            .full          (full[g]),
            .almost_full   (almost_full[g]),
            .wr_level      (wr_level[g]),
            .wr_overflow   (wr_overflow[g]),
            .wr_err_clr    (wr_err_clr),
            .cfg_af_thresh (cfg_af_thresh),
            .rd_en         (rd_en[g]),
            .rd_data       (rd_data[g]),
            .rd_valid      (rd_valid[g]),
            .empty         (empty[g]),
            .almost_empty  (almost_empty[g]),
            .rd_level      (rd_level[g]),
            .rd_underflow  (rd_underflow[g]),
            .rd_err_clr    (rd_err_clr),
            .cfg_ae_thresh (cfg_ae_thresh)
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr_tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic rd_tick();
        @(posedge rd_clk);
        #1;
    endtask

    function automatic void sb_push(input int m, input logic [7:0] d);
        if (m == 0) sb_q0.push_back(d);
        else        sb_q1.push_back(d);
    endfunction

    function automatic int sb_size(input int m);
        return (m == 0) ? sb_q0.size() : sb_q1.size();
    endfunction

    // Compare rd_data of instance m against the oldest scoreboard entry.
    task automatic pop_check(input int m, input string tag);
        logic [7:0] exp;
        if (sb_size(m) == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            if (m == 0) exp = sb_q0.pop_front();
            else        exp = sb_q1.pop_front();
            check_val(tag, 32'(rd_data[m]), 32'(exp));
        end
    endtask

    task automatic write_word(input int m, input logic [7:0] d);
        wr_data[m] = d;
        wr_en[m]   = 1'b1;
        if (!full[m]) sb_push(m, d);
        wr_tick();
        wr_en[m] = 1'b0;
    endtask

    task automatic check_reset_vals(input string ph);
        for (int m = 0; m < 2; m++) begin
            check_val({ph, "_full"},      32'(full[m]),         32'd0);
            check_val({ph, "_afull"},     32'(almost_full[m]),  32'd0);
            check_val({ph, "_wr_level"},  32'(wr_level[m]),     32'd0);
            check_val({ph, "_overflow"},  32'(wr_overflow[m]),  32'd0);
            check_val({ph, "_empty"},     32'(empty[m]),        32'd1);
            check_val({ph, "_aempty"},    32'(almost_empty[m]), 32'd1);
            check_val({ph, "_rd_valid"},  32'(rd_valid[m]),     32'd0);
            check_val({ph, "_rd_data"},   32'(rd_data[m]),      32'd0);
            check_val({ph, "_rd_level"},  32'(rd_level[m]),     32'd0);
            check_val({ph, "_underflow"}, 32'(rd_underflow[m]), 32'd0);
        end
    endtask

    // Wait (bounded) for a word, then read it in the mode of instance m.
    task automatic read_one(input int m);
        int w = 0;
        while (((m == 0) ? empty[0] : !rd_valid[1]) && w < 40) begin
            rd_tick();
            w++;
        end
        check_val("rd_wait_bound", 32'(w < 40), 32'd1);
        if (m == 0) begin
            check_val("std_no_early_valid", 32'(rd_valid[0]), 32'd0);
            rd_en[0] = 1'b1;
            rd_tick();
            rd_en[0] = 1'b0;
            check_val("std_valid", 32'(rd_valid[0]), 32'd1);
            pop_check(0, "std_data");
            rd_tick();
            check_val("std_valid_pulse", 32'(rd_valid[0]), 32'd0);
        end else begin
            pop_check(1, "fwft_data");
            rd_en[1] = 1'b1;
            rd_tick();
            rd_en[1] = 1'b0;
        end
    endtask

    task automatic stress_writer(input int m, input int n);
        int sent = 0;
        int guard = 0;
        wr_tick();
        while (sent < n && guard < 40000) begin
            if (!full[m] && $urandom_range(0, 1) == 1) begin
                wr_data[m] = 8'($urandom);
                wr_en[m]   = 1'b1;
                sb_push(m, wr_data[m]);
                sent++;
            end else begin
                wr_en[m] = 1'b0;
            end
            wr_tick();
            guard++;
        end
        wr_en[m] = 1'b0;
        check_val("stress_wr_bound", 32'(sent), 32'(n));
    endtask

    task automatic stress_reader(input int m, input int n);
        int   got = 0;
        int   guard = 0;
        logic pending = 1'b0;
        rd_tick();
        while (got < n && guard < 40000) begin
            if (m == 0) begin
                if (pending) begin
                    check_val("stress_std_valid", 32'(rd_valid[0]), 32'd1);
                    pop_check(0, "stress_std_data");
                    got++;
                end
                pending  = (got < n) && !empty[0] && ($urandom_range(0, 1) == 1);
                rd_en[0] = pending;
            end else begin
                if (rd_valid[1] && $urandom_range(0, 1) == 1) begin
                    pop_check(1, "stress_fwft_data");
                    rd_en[1] = 1'b1;
                    got++;
                end else begin
                    rd_en[1] = 1'b0;
                end
            end
            rd_tick();
            guard++;
        end
        rd_en[m] = 1'b0;
        check_val("stress_rd_bound", 32'(got), 32'(n));
    endtask

    task automatic stress_post(input string ph);
        repeat (12) rd_tick();
        for (int m = 0; m < 2; m++) begin
            check_val({ph, "_sb_drained"}, 32'(sb_size(m)),     32'd0);
            check_val({ph, "_overflow"},   32'(wr_overflow[m]), 32'd0);
            check_val({ph, "_underflow"},  32'(rd_underflow[m]),32'd0);
            check_val({ph, "_empty"},      32'(empty[m]),       32'd1);
        end
    endtask

    initial begin
        int lat;
        wr_rst_n = 1'b0;
        rd_rst_n = 1'b0;
        wr_err_clr = 1'b0;
        rd_err_clr = 1'b0;
        cfg_af_thresh = 4'd6;
        cfg_ae_thresh = 4'd2;
        for (int m = 0; m < 2; m++) begin
            wr_en[m] = 1'b0;
            rd_en[m] = 1'b0;
            wr_data[m] = 8'h00;
        end
        #30;
        check_reset_vals("rst");
        @(negedge wr_clk) wr_rst_n = 1'b1;
        @(negedge rd_clk) rd_rst_n = 1'b1;

        // Fill the standard-mode instance with the reader idle.
        wr_tick();
        for (int i = 1; i <= 8; i++) begin
            write_word(0, 8'(i));
            if (i == 5) check_val("af_below", 32'(almost_full[0]), 32'd0);
            if (i == 6) check_val("af_at_6", 32'(almost_full[0]), 32'd1);
            if (i == 7) check_val("full_early", 32'(full[0]), 32'd0);
        end
        check_val("full_after_8", 32'(full[0]), 32'd1);
        check_val("wr_level_8", 32'(wr_level[0]), 32'd8);
        write_word(0, 8'hFF);
        check_val("overflow_set", 32'(wr_overflow[0]), 32'd1);
        check_val("wr_level_hold", 32'(wr_level[0]), 32'd8);
        wr_err_clr = 1'b1;
        write_word(0, 8'hEE);
        wr_err_clr = 1'b0;
        check_val("overflow_clr_wins", 32'(wr_overflow[0]), 32'd0);

        // Standard-mode back-to-back drain with level/threshold tracking.
        repeat (8) rd_tick();
        check_val("std_rd_level_8", 32'(rd_level[0]), 32'd8);
        check_val("std_aempty_full", 32'(almost_empty[0]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            rd_en[0] = 1'b1;
            rd_tick();
            check_val("std_drain_valid", 32'(rd_valid[0]), 32'd1);
            pop_check(0, "std_drain_data");
            check_val("std_drain_level", 32'(rd_level[0]), 32'(8 - k));
            check_val("std_drain_aempty", 32'(almost_empty[0]), 32'((8 - k) <= 2));
        end
        check_val("std_empty_after", 32'(empty[0]), 32'd1);
        rd_tick();
        rd_en[0] = 1'b0;
        check_val("std_underflow", 32'(rd_underflow[0]), 32'd1);
        check_val("std_no_valid_empty", 32'(rd_valid[0]), 32'd0);
        rd_err_clr = 1'b1;
        rd_tick();
        rd_err_clr = 1'b0;
        check_val("std_underflow_clr", 32'(rd_underflow[0]), 32'd0);

        // FWFT: first-word latency, then a bubble-free drain.
        wr_tick();
        lat = 0;
        fork
            begin
                for (int i = 1; i <= 8; i++) write_word(1, 8'(i));
            end
            begin
                while (!rd_valid[1] && lat < 20) begin
                    rd_tick();
                    lat++;
                end
                check_val("fwft_latency_window", 32'(lat >= SS + 1 && lat <= SS + 4), 32'd1);
                check_val("fwft_first_word", 32'(rd_data[1]), 32'h01);
            end
        join
        repeat (12) rd_tick();
        check_val("fwft_rd_level_8", 32'(rd_level[1]), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            check_val("fwft_nobubble", 32'(rd_valid[1]), 32'd1);
            pop_check(1, "fwft_drain_data");
            check_val("fwft_drain_level", 32'(rd_level[1]), 32'(9 - k));
            check_val("fwft_drain_aempty", 32'(almost_empty[1]), 32'((9 - k) <= 2));
            rd_en[1] = 1'b1;
            rd_tick();
        end
        check_val("fwft_valid_gone", 32'(rd_valid[1]), 32'd0);
        check_val("fwft_empty", 32'(empty[1]), 32'd1);
        check_val("fwft_level_0", 32'(rd_level[1]), 32'd0);
        rd_tick();
        rd_en[1] = 1'b0;
        check_val("fwft_underflow", 32'(rd_underflow[1]), 32'd1);
        rd_err_clr = 1'b1;
        rd_tick();
        rd_err_clr = 1'b0;
        check_val("fwft_underflow_clr", 32'(rd_underflow[1]), 32'd0);

        // Standard mode single word.
        wr_tick();
        write_word(0, 8'h5A);
        rd_tick();
        read_one(0);
        check_val("std_data_hold", 32'(rd_data[0]), 32'h5A);

        // Reset with five words stored in each instance.
        wr_tick();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 5; i++) write_word(m, 8'(8'h30 + i));
        end
        repeat (10) rd_tick();
        wr_rst_n = 1'b0;
        rd_rst_n = 1'b0;
        #3;
        check_reset_vals("midrst");
        sb_q0.delete();
        sb_q1.delete();
        #20;
        @(negedge wr_clk) wr_rst_n = 1'b1;
        @(negedge rd_clk) rd_rst_n = 1'b1;
        wr_tick();
        write_word(0, 8'hA5);
        write_word(1, 8'hA5);
        rd_tick();
        read_one(0);
        read_one(1);

        // Random traffic through many pointer wraps, fast writer then fast reader.
        wr_half = 5.0;
        rd_half = 13.5;
        fork
            stress_writer(0, NWORD);
            stress_writer(1, NWORD);
            stress_reader(0, NWORD);
            stress_reader(1, NWORD);
        join
        stress_post("stress_a");
        wr_half = 13.5;
        rd_half = 5.0;
        fork
            stress_writer(0, NWORD);
            stress_writer(1, NWORD);
            stress_reader(0, NWORD);
            stress_reader(1, NWORD);
        join
        stress_post("stress_b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
